// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: serial LSD-first BCD adder/subtractor, one decimal digit per clock
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic                cin,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state;
    logic [W-1:0] a_r, b_r, b_eff;
    logic [CW-1:0] cnt;
    logic carry, bad, gt9;
    logic [3:0] ad, bd, dig;
    logic [4:0] s, s6;
    // subtraction runs as A + 9's-complement(B) + ~borrow, i.e. ten's complement
    always_comb begin
        b_eff = b;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            b_eff[4*i +: 4] = op ? 4'd9 - b[4*i +: 4] : b[4*i +: 4];
            bad = bad | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
        end
    end
    assign ad  = a_r[{cnt, 2'b00} +: 4];
    assign bd  = b_r[{cnt, 2'b00} +: 4];
    assign s   = {1'b0, ad} + {1'b0, bd} + {4'd0, carry};
    assign s6  = s + 5'd6;
    assign gt9 = s > 5'd9;
    assign dig = gt9 ? s6[3:0] : s[3:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b_eff;
                        carry <= op ? ~cin : cin;
                        err   <= bad;
                        cnt   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum[{cnt, 2'b00} +: 4] <= dig;
                    carry <= gt9;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(DIGITS - 1)) begin
                        cout  <= gt9;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
